// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: op codes, bus select codes,
// carry-in modes, FSM states and the latched command record.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SWAP = 4'd7,
        OP_MOV  = 4'd8
    } op_e;

    localparam logic [3:0] OUT_REG_A  = 4'd0;
    localparam logic [3:0] OUT_REG_B  = 4'd1;
    localparam logic [3:0] OUT_REG_C  = 4'd2;
    localparam logic [3:0] OUT_REG_D  = 4'd3;
    localparam logic [3:0] OUT_FLAGS  = 4'd4;
    localparam logic [3:0] OUT_ADDSUB = 4'd5;
    localparam logic [3:0] OUT_ANDOR  = 4'd6;
    localparam logic [3:0] OUT_SHSW   = 4'd7;
    localparam logic [3:0] OUT_XORNOT = 4'hA;

    localparam logic [3:0] LOAD_REG_A = 4'd0;
    localparam logic [3:0] LOAD_REG_B = 4'd1;
    localparam logic [3:0] LOAD_REG_C = 4'd2;
    localparam logic [3:0] LOAD_REG_D = 4'd3;
    localparam logic [3:0] LOAD_FLAGS = 4'd7;

    localparam logic [2:0] ARG_R_ZERO = 3'd6;
    localparam int         FLAG_C     = 1;

    localparam logic [1:0] CMODE_ZERO  = 2'd0;
    localparam logic [1:0] CMODE_ONE   = 2'd1;
    localparam logic [1:0] CMODE_FLAGS = 2'd2;
    localparam logic [1:0] CMODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] src_l;
        logic [2:0] src_r;
        logic [2:0] count;
        logic [1:0] cmode;
        logic       fonly;
    } cmd_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op-code decode: result bus driver, function variant,
// whether the flags latch is enabled, and illegal-code detection.
module alu_op_decode
    import alu_seq_pkg::*;
#(
    parameter logic [3:0] IDLE_OUT = 4'hF
) (
    input  logic [3:0] op,
    input  logic [1:0] src_l,
    output logic [3:0] outctl,
    output logic       alt,
    output logic       calc_en,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        outctl  = IDLE_OUT;
        alt     = 1'b0;
        calc_en = 1'b1;
        illegal = 1'b0;
        case (op)
            OP_ADD:  outctl = OUT_ADDSUB;
            OP_SUB:  begin outctl = OUT_ADDSUB; alt = 1'b1; end
            OP_AND:  outctl = OUT_ANDOR;
            OP_OR:   begin outctl = OUT_ANDOR;  alt = 1'b1; end
            OP_XOR:  outctl = OUT_XORNOT;
            OP_NOT:  begin outctl = OUT_XORNOT; alt = 1'b1; end
            OP_SHR:  outctl = OUT_SHSW;
            OP_SWAP: begin outctl = OUT_SHSW;   alt = 1'b1; end
            OP_MOV:  begin outctl = {2'b00, src_l}; calc_en = 1'b0; end
            default: begin calc_en = 1'b0; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU control sequencer: accepts one command per handshake and replays it as
// 1..8 SETUP/EXEC passes on the registered ALU control bus.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  IDLE_OUT      = 4'hF,
    parameter logic [3:0]  IDLE_LOAD     = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src_l,
    input  logic [2:0] cmd_src_r,
    input  logic [2:0] cmd_count,
    input  logic [1:0] cmd_cmode,
    input  logic       cmd_fonly,
    input  logic [3:0] fout,
    output logic [3:0] outctl,
    output logic [3:0] loadctl,
    output logic [1:0] arg_l,
    output logic [2:0] arg_r,
    output logic       alt,
    output logic       calcfn,
    output logic       cin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic [2:0] settle_q, settle_d;
    logic [2:0] iter_q, iter_d;

    logic [3:0] outctl_q, outctl_d;
    logic [3:0] loadctl_q, loadctl_d;
    logic [1:0] arg_l_q, arg_l_d;
    logic [2:0] arg_r_q, arg_r_d;
    logic       alt_q, alt_d;
    logic       calcfn_q, calcfn_d;
    logic       cin_q, cin_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       accept;
    logic [3:0] dec_outctl;
    logic       dec_alt;
    logic       dec_calc_en;
    logic       dec_illegal;
    logic [3:0] fout_unused;

    assign cmd_ready   = (state_q == ST_IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign fout_unused = fout & ~(4'b0001 << FLAG_C);

    // Decode always looks at the command that will be active next cycle.
    alu_op_decode #(
        .IDLE_OUT (IDLE_OUT)
    ) u_decode (
        .op      (cmd_d.op),
        .src_l   (cmd_d.src_l),
        .outctl  (dec_outctl),
        .alt     (dec_alt),
        .calc_en (dec_calc_en),
        .illegal (dec_illegal)
    );

    always_comb begin
        cmd_d = cmd_q;
        if (accept) begin
            cmd_d = '{op: cmd_op, dst: cmd_dst, src_l: cmd_src_l, src_r: cmd_src_r,
                      count: cmd_count, cmode: cmd_cmode, fonly: cmd_fonly};
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        iter_d   = iter_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        settle_d = 3'd0;
                        iter_d   = 3'd0;
                    end
                end
            end
            ST_SETUP: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_EXEC;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            ST_EXEC: begin
                if (iter_q == cmd_q.count) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_SETUP;
                    settle_d = 3'd0;
                    iter_d   = iter_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus values are derived from the next state so each one is registered and held a full cycle.
    always_comb begin
        outctl_d  = IDLE_OUT;
        loadctl_d = IDLE_LOAD;
        arg_l_d   = 2'd0;
        arg_r_d   = ARG_R_ZERO;
        alt_d     = 1'b0;
        calcfn_d  = 1'b1;
        cin_d     = 1'b0;
        busy_d    = 1'b0;
        if (state_d != ST_IDLE) begin
            arg_l_d = cmd_d.src_l;
            arg_r_d = cmd_d.src_r;
            alt_d   = dec_alt;
            cin_d   = (cmd_d.cmode == CMODE_ONE);
            busy_d  = 1'b1;
        end
        if (state_d == ST_EXEC) begin
            outctl_d  = dec_outctl;
            loadctl_d = cmd_d.fonly ? IDLE_LOAD : {2'b00, cmd_d.dst};
            calcfn_d  = !dec_calc_en;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            settle_q  <= 3'd0;
            iter_q    <= 3'd0;
            outctl_q  <= IDLE_OUT;
            loadctl_q <= IDLE_LOAD;
            arg_l_q   <= 2'd0;
            arg_r_q   <= ARG_R_ZERO;
            alt_q     <= 1'b0;
            calcfn_q  <= 1'b1;
            cin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            settle_q  <= settle_d;
            iter_q    <= iter_d;
            outctl_q  <= outctl_d;
            loadctl_q <= loadctl_d;
            arg_l_q   <= arg_l_d;
            arg_r_q   <= arg_r_d;
            alt_q     <= alt_d;
            calcfn_q  <= calcfn_d;
            cin_q     <= cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Flags-carry mode bypasses the register so each pass sees the previous pass's carry.
    assign cin = (state_q != ST_IDLE && cmd_q.cmode == CMODE_FLAGS) ? fout[FLAG_C] : cin_q;

    assign outctl  = outctl_q;
    assign loadctl = loadctl_q;
    assign arg_l   = arg_l_q;
    assign arg_r   = arg_r_q;
    assign alt     = alt_q;
    assign calcfn  = calcfn_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of single commands checked cycle by
// cycle, plus illegal-op, reset-mid-command and back-to-back sequences.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int S = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_l;
    logic [2:0] cmd_src_r;
    logic [2:0] cmd_count;
    logic [1:0] cmd_cmode;
    logic       cmd_fonly;
    logic [3:0] fout;
    logic [3:0] outctl;
    logic [3:0] loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic       alt;
    logic       calcfn;
    logic       cin;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .SETTLE_CYCLES (S),
        .IDLE_OUT      (4'hF),
        .IDLE_LOAD     (4'hF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src_l (cmd_src_l),
        .cmd_src_r (cmd_src_r),
        .cmd_count (cmd_count),
        .cmd_cmode (cmd_cmode),
        .cmd_fonly (cmd_fonly),
        .fout      (fout),
        .outctl    (outctl),
        .loadctl   (loadctl),
        .arg_l     (arg_l),
        .arg_r     (arg_r),
        .alt       (alt),
        .calcfn    (calcfn),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] src_l;
        logic [2:0] src_r;
        logic [2:0] count;
        logic [1:0] cmode;
        logic       fonly;
        logic [3:0] fout;
        logic [3:0] e_out;
        logic [3:0] e_load;
        logic       e_alt;
        logic       e_calcfn;
        logic       e_cin;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] pack(input logic b, input logic [3:0] o, input logic [3:0] l,
                                         input logic [1:0] al, input logic [2:0] ar, input logic a,
                                         input logic cf, input logic ci, input logic d, input logic e);
        return {13'd0, b, o, l, al, ar, a, cf, ci, d, e};
    endfunction

    function automatic logic [31:0] dut_bus();
        return pack(busy, outctl, loadctl, arg_l, arg_r, alt, calcfn, cin, done, err);
    endfunction

    logic [31:0] idle_bus;
    logic [31:0] done_bus;
    logic [31:0] err_bus;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%05h, want 0x%05h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_op    = v.op;
        cmd_dst   = v.dst;
        cmd_src_l = v.src_l;
        cmd_src_r = v.src_r;
        cmd_count = v.count;
        cmd_cmode = v.cmode;
        cmd_fonly = v.fonly;
        fout      = v.fout;
    endtask

    function automatic logic [31:0] setup_bus(input vec_t v);
        return pack(1'b1, 4'hF, 4'hF, v.src_l, v.src_r, v.e_alt, 1'b1, v.e_cin, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] exec_bus(input vec_t v);
        return pack(1'b1, v.e_out, v.e_load, v.src_l, v.src_r, v.e_alt, v.e_calcfn, v.e_cin, 1'b0, 1'b0);
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int passes;
        @(negedge clk);
        drive_cmd(v);
        cmd_valid = 1'b1;
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        passes = int'(v.count) + 1;
        for (int c = 1; c <= passes * (S + 1); c++) begin
            @(negedge clk);
            if (((c - 1) % (S + 1)) < S)
                check($sformatf("%s setup c%0d", tag, c), dut_bus(), setup_bus(v));
            else
                check($sformatf("%s exec c%0d", tag, c), dut_bus(), exec_bus(v));
        end
        @(negedge clk);
        check({tag, " done"}, dut_bus(), done_bus);
        check({tag, " done ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;

        idle_bus = pack(1'b0, 4'hF, 4'hF, 2'd0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        done_bus = pack(1'b0, 4'hF, 4'hF, 2'd0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        err_bus  = pack(1'b0, 4'hF, 4'hF, 2'd0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        //          op       dst   src_l src_r count cmode fonly fout     out   load  alt   calcfn cin
        vecs[0] = '{OP_ADD,  2'd0, 2'd1, 3'd2, 3'd0, 2'd0, 1'b0, 4'b0000, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{OP_SHR,  2'd3, 2'd3, 3'd6, 3'd3, 2'd0, 1'b0, 4'b0000, 4'h7, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{OP_SUB,  2'd0, 2'd0, 3'd6, 3'd0, 2'd2, 1'b1, 4'b0010, 4'h5, 4'hF, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{OP_OR,   2'd2, 2'd1, 3'd0, 3'd1, 2'd1, 1'b0, 4'b0000, 4'h6, 4'h2, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{OP_XOR,  2'd1, 2'd2, 3'd3, 3'd0, 2'd3, 1'b0, 4'b0010, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{OP_NOT,  2'd0, 2'd0, 3'd6, 3'd0, 2'd0, 1'b0, 4'b0000, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{OP_SWAP, 2'd1, 2'd1, 3'd0, 3'd0, 2'd0, 1'b0, 4'b0000, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{OP_MOV,  2'd2, 2'd3, 3'd6, 3'd0, 2'd0, 1'b0, 4'b0000, 4'h3, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{OP_AND,  2'd3, 2'd0, 3'd1, 3'd7, 2'd2, 1'b0, 4'b1101, 4'h6, 4'h3, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        drive_cmd(vecs[0]);
        #2;
        check("reset bus", dut_bus(), idle_bus);
        check("reset ready low", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset bus", dut_bus(), idle_bus);
        check("post-reset ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Illegal op codes: no SETUP/EXEC, done+err one cycle after accept.
        for (int i = 0; i < 2; i++) begin
            rv    = vecs[0];
            rv.op = (i == 0) ? 4'hC : 4'h9;
            @(negedge clk);
            drive_cmd(rv);
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            check($sformatf("illegal%0d done/err", i), dut_bus(), err_bus);
            check($sformatf("illegal%0d ready", i), 32'(cmd_ready), 32'd1);
            @(negedge clk);
            check($sformatf("illegal%0d after", i), dut_bus(), idle_bus);
        end

        // Reset during the second EXEC of a three-pass command.
        rv       = vecs[0];
        rv.count = 3'd2;
        rv.cmode = 2'd1;
        rv.e_cin = 1'b1;
        @(negedge clk);
        drive_cmd(rv);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst pre exec2", dut_bus(), exec_bus(rv));
        #1 rst = 1'b1;
        #1;
        check("rst async bus", dut_bus(), idle_bus);
        check("rst async ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst no done c%0d", c), dut_bus(), idle_bus);
        end
        run_vec(vecs[6], "after-rst");

        // Back-to-back: valid held, second command accepted in the first's done cycle.
        @(negedge clk);
        drive_cmd(vecs[0]);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 drive_cmd(vecs[6]);
        @(negedge clk);
        check("b2b first setup", dut_bus(), setup_bus(vecs[0]));
        check("b2b busy ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("b2b first exec", dut_bus(), exec_bus(vecs[0]));
        @(negedge clk);
        check("b2b first done", dut_bus(), done_bus);
        check("b2b done ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b second setup", dut_bus(), setup_bus(vecs[6]));
        @(negedge clk);
        check("b2b second exec", dut_bus(), exec_bus(vecs[6]));
        @(negedge clk);
        check("b2b second done", dut_bus(), done_bus);
        @(negedge clk);
        check("b2b idle", dut_bus(), idle_bus);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
